// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types, line/beat geometry and the state
// encoding of the line responder.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [255:0] lc3b_32bytes;
  typedef logic [63:0]  lc3b_beat;

  // A 32-byte line moves as four 64-bit beats.
  localparam int unsigned LC3B_BEATS_PER_LINE = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_XFER  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DELAY = 3'd3,
    ST_RESP  = 3'd4,
    ST_COOL  = 3'd5
  } pmem_state_e;

  // Align a byte address down to its 32-byte line.
  function automatic lc3b_word line_base(input lc3b_word addr);
    return {addr[15:5], 5'b00000};
  endfunction

  // Byte address of beat idx within the line starting at base.
  function automatic lc3b_word beat_addr(input lc3b_word base, input logic [1:0] idx);
    return base + {11'd0, idx, 3'b000};
  endfunction

endpackage

// File: rtl/pmem_line_responder_assembler.sv
// Packs in-order 64-bit read beats into a 256-bit line. The line itself is
// only cleared by reset, so a completed line stays visible until the next
// read's first beat overwrites slot 0.
module line_beat_assembler
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        beat_valid,
  input  lc3b_beat    beat,
  output lc3b_32bytes line,
  output logic        full,
  output logic        last_beat
);

  lc3b_32bytes line_d, line_q;
  logic [1:0]  cnt_d, cnt_q;
  logic        full_d, full_q;

  // Store each accepted beat at the return pointer; beats past the fourth are dropped.
  always_comb begin
    line_d = line_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    if (clear) begin
      cnt_d  = 2'd0;
      full_d = 1'b0;
    end else if (beat_valid && !full_q) begin
      line_d[{cnt_q, 6'b000000} +: 64] = beat;
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        full_d = 1'b1;
      end else begin
        full_d = 1'b0;
      end
    end else begin
      full_d = full_q;
    end
  end

  // Line, return pointer and full flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      cnt_q  <= 2'd0;
      full_q <= 1'b0;
    end else begin
      line_q <= line_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign line      = line_q;
  assign full      = full_q;
  assign last_beat = beat_valid && !full_q && (cnt_q == 2'd3);

endmodule

// File: rtl/pmem_line_responder.sv
// Serves one 32-byte line read or write as four 64-bit beats on the beat
// bus, then pulses pmem_resp for one cycle. All outputs are registered; the
// first XFER cycle loads the beat outputs, so beat 0 is presented one cycle
// after the request is latched.
module pmem_line_responder
  import lc3b_types::*;
#(
  parameter int RESP_DELAY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  lc3b_word    pmem_address,
  input  lc3b_32bytes pmem_wdata,
  output lc3b_32bytes pmem_rdata,
  output logic        pmem_resp,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [63:0] mem_wbeat,
  input  logic        mem_ready,
  input  logic [63:0] mem_rbeat,
  input  logic        mem_rvalid
);

  localparam int DLY_W = (RESP_DELAY > 0) ? $clog2(RESP_DELAY + 1) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((RESP_DELAY > 0) ? (RESP_DELAY - 1) : 0);

  pmem_state_e      state_d, state_q;
  lc3b_word         base_d, base_q;
  logic             op_d, op_q;            // 1 = line write
  lc3b_32bytes      wline_d, wline_q;
  logic [1:0]       issue_d, issue_q;
  logic [DLY_W-1:0] delay_d, delay_q;

  logic             mem_req_d, mem_req_q;
  logic             mem_we_d, mem_we_q;
  lc3b_word         mem_addr_d, mem_addr_q;
  lc3b_beat         mem_wbeat_d, mem_wbeat_q;
  logic             pmem_resp_d, pmem_resp_q;

  logic             accept_s;
  logic             beat_take_s;
  logic             clear_s;
  logic             ret_full_s;
  logic             ret_last_s;
  logic             returns_done_s;
  pmem_state_e      done_state_s;

  assign accept_s       = mem_req_q & mem_ready;
  assign clear_s        = (state_q == ST_IDLE) & (pmem_read | pmem_write);
  assign beat_take_s    = mem_rvalid & ~op_q &
                          ((state_q == ST_XFER) | (state_q == ST_DRAIN));
  assign returns_done_s = ret_full_s | ret_last_s;

  line_beat_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear_s),
    .beat_valid (beat_take_s),
    .beat       (mem_rbeat),
    .line       (pmem_rdata),
    .full       (ret_full_s),
    .last_beat  (ret_last_s)
  );

  // Where a finished transfer goes: straight to RESP when no idle gap is configured.
  always_comb begin
    if (RESP_DELAY == 0) begin
      done_state_s = ST_RESP;
    end else begin
      done_state_s = ST_DELAY;
    end
  end

  // Next-state logic, request latching and beat/delay counters.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    op_d    = op_q;
    wline_d = wline_q;
    issue_d = issue_q;
    delay_d = delay_q;
    case (state_q)
      ST_IDLE: begin
        if (pmem_read || pmem_write) begin
          // A simultaneous read and write is served as the write.
          base_d  = line_base(pmem_address);
          op_d    = pmem_write;
          wline_d = pmem_wdata;
          issue_d = 2'd0;
          delay_d = '0;
          state_d = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (accept_s) begin
          issue_d = issue_q + 2'd1;
          if (issue_q == 2'd3) begin
            if (op_q || returns_done_s) begin
              state_d = done_state_s;
            end else begin
              state_d = ST_DRAIN;
            end
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_DRAIN: begin
        if (returns_done_s) begin
          state_d = done_state_s;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DELAY: begin
        if (delay_q == DLY_LAST) begin
          delay_d = '0;
          state_d = ST_RESP;
        end else begin
          delay_d = delay_q + DLY_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_COOL;
      end
      ST_COOL: begin
        // Requester is still dropping its request here; ignore it.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered beat-bus and response outputs, computed one cycle ahead.
  always_comb begin
    mem_req_d   = (state_q == ST_XFER) && !(accept_s && (issue_q == 2'd3));
    mem_we_d    = 1'b0;
    mem_addr_d  = 16'h0000;
    mem_wbeat_d = 64'h0;
    if (mem_req_d) begin
      mem_we_d    = op_q;
      mem_addr_d  = beat_addr(base_q, issue_d);
      mem_wbeat_d = wline_q[{issue_d, 6'b000000} +: 64];
    end else begin
      mem_we_d    = 1'b0;
    end
    pmem_resp_d = (state_d == ST_RESP);
  end

  // State, latched request and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= 16'h0000;
      op_q        <= 1'b0;
      wline_q     <= '0;
      issue_q     <= 2'd0;
      delay_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wbeat_q <= 64'h0;
      pmem_resp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      op_q        <= op_d;
      wline_q     <= wline_d;
      issue_q     <= issue_d;
      delay_q     <= delay_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wbeat_q <= mem_wbeat_d;
      pmem_resp_q <= pmem_resp_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wbeat = mem_wbeat_q;
  assign pmem_resp = pmem_resp_q;

endmodule
